// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the wide carry-select add sequencer.
package csa_seq_pkg;

  localparam int WORD_W    = 16;
  localparam int WORDS_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sixteen_bits_select_adder.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing both carry
// outcomes so the carry chain is only a row of muxes.
module sixteen_bits_select_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [4:0] blk_carry;

  assign blk_carry[0] = Cin;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [4:0] sum0;
    logic [4:0] sum1;

    // Both speculative sums are ready before the incoming carry arrives.
    assign sum0 = {1'b0, A[g*4 +: 4]} + {1'b0, B[g*4 +: 4]};
    assign sum1 = sum0 + 5'd1;

    assign S[g*4 +: 4]     = blk_carry[g] ? sum1[3:0] : sum0[3:0];
    assign blk_carry[g+1]  = blk_carry[g] ? sum1[4]   : sum0[4];
  end

  assign Cout = blk_carry[4];

endmodule

// File: rtl/csa_wide_add_seq.sv
// Wide add (optionally subtract with CSA_SEQ_SUB_EN) built from one 16-bit
// carry-select adder, processing one word per cycle, least significant first.
module csa_wide_add_seq
  import csa_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_cin,
`ifdef CSA_SEQ_SUB_EN
  input  logic                      req_sub,
`endif
  input  logic [WORD_W*WORDS-1:0]   req_a,
  input  logic [WORD_W*WORDS-1:0]   req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WORD_W*WORDS-1:0]   res_sum,
  output logic                      res_cout
);

  localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t                    state;
  logic [WORD_W*WORDS-1:0]   a_q;
  logic [WORD_W*WORDS-1:0]   b_q;
  logic                      carry;
  logic [IDX_W-1:0]          idx;

  logic [WORD_W-1:0]         word_a;
  logic [WORD_W-1:0]         word_b_raw;
  logic [WORD_W-1:0]         word_b;
  logic [WORD_W-1:0]         word_s;
  logic                      word_cout;

  assign word_a     = a_q[idx*WORD_W +: WORD_W];
  assign word_b_raw = b_q[idx*WORD_W +: WORD_W];

`ifdef CSA_SEQ_SUB_EN
  logic sub_q;

  // Subtraction is a + ~b + 1; the +1 comes from the preloaded carry.
  assign word_b = sub_q ? ~word_b_raw : word_b_raw;
`else
  assign word_b = word_b_raw;
`endif

  sixteen_bits_select_adder u_adder (
    .A    (word_a),
    .B    (word_b),
    .Cin  (carry),
    .S    (word_s),
    .Cout (word_cout)
  );

  // Handshake flags are registered alongside the state so no input reaches
  // an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef CSA_SEQ_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q       <= req_a;
            b_q       <= req_b;
`ifdef CSA_SEQ_SUB_EN
            sub_q     <= req_sub;
            carry     <= req_sub ? 1'b1 : req_cin;
`else
            carry     <= req_cin;
`endif
            idx       <= '0;
            req_ready <= 1'b0;
            state     <= RUN;
          end
        end

        RUN: begin
          res_sum[idx*WORD_W +: WORD_W] <= word_s;
          carry                         <= word_cout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            res_cout  <= word_cout;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          res_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_wide_add_seq.sv
// Directed self-checking bench for csa_wide_add_seq (WORDS=4 plus a WORDS=1
// instance); subtract scenarios run when CSA_SEQ_SUB_EN is defined.
module tb_csa_wide_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_cin;
  logic [63:0] req_a, req_b;
  logic        res_valid, res_ready, res_cout;
  logic [63:0] res_sum;

  logic        req_valid1, req_ready1, req_cin1;
  logic [15:0] req_a1, req_b1;
  logic        res_valid1, res_ready1, res_cout1;
  logic [15:0] res_sum1;
`ifdef CSA_SEQ_SUB_EN
  logic        req_sub, req_sub1;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  csa_wide_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cin(req_cin),
`ifdef CSA_SEQ_SUB_EN
    .req_sub(req_sub),
`endif
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout)
  );

  csa_wide_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_cin(req_cin1),
`ifdef CSA_SEQ_SUB_EN
    .req_sub(req_sub1),
`endif
    .req_a(req_a1), .req_b(req_b1),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_sum(res_sum1), .res_cout(res_cout1)
  );

  // Called #1 after a clock edge; returns #1 after the accept edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic cin, output bit accepted);
    int n = 0;
    req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    accepted = req_ready;
    if (accepted) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 50) begin
      @(posedge clk); #1; cycles++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, res_valid, res_cout} !== 3'b100 || res_sum !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got rdy/vld/cout=%b sum=%h expected 100 sum=0",
               {req_ready, res_valid, res_cout}, res_sum);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple();
    bit acc; int cyc;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, acc);
    tests_run++;
    if (!acc || req_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ripple_accept: got accepted=%0d req_ready=%b expected 1 0", acc, req_ready);
    end
    wait_result(cyc);
    tests_run++;
    if (cyc !== 4) begin
      tests_failed++;
      $display("[TB] FAIL ripple_latency: got %0d expected 4", cyc);
    end
    tests_run++;
    if (res_sum !== 64'h0 || res_cout !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ripple_result: got sum=%h cout=%b expected 0 1", res_sum, res_cout);
    end
    release_result();
    tests_run++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ripple_return_idle: got rdy=%b vld=%b expected 1 0", req_ready, res_valid);
    end
  endtask

  task automatic test_carry_in();
    bit acc; int cyc;
    applyStimulus(64'h0, 64'h0, 1'b1, acc);
    wait_result(cyc);
    tests_run++;
    if (!acc || res_sum !== 64'h0000_0000_0000_0001 || res_cout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cin_only: got acc=%0d sum=%h cout=%b expected 1 0000000000000001 0",
               acc, res_sum, res_cout);
    end
    release_result();
    applyStimulus(64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 1'b0, acc);
    wait_result(cyc);
    tests_run++;
    if (!acc || res_sum !== 64'h3333_3333_3333_3332 || res_cout !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL add_9999: got acc=%0d sum=%h cout=%b expected 1 3333333333333332 1",
               acc, res_sum, res_cout);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    bit acc; int cyc;
    applyStimulus(64'h1, 64'h1, 1'b0, acc);
    wait_result(cyc);
    req_a = 64'h7; req_b = 64'h8; req_cin = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({res_valid, req_ready, res_cout} !== 3'b100 || res_sum !== 64'h2) begin
        tests_failed++;
        $display("[TB] FAIL backpressure_hold[%0d]: got vld/rdy/cout=%b sum=%h expected 100 sum=2",
                 i, {res_valid, req_ready, res_cout}, res_sum);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_no_b2b: got rdy=%b vld=%b expected 1 0", req_ready, res_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_accept: got rdy=%b expected 0", req_ready);
    end
    wait_result(cyc);
    tests_run++;
    if (cyc !== 4 || res_sum !== 64'hF || res_cout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_new_req: got cyc=%0d sum=%h cout=%b expected 4 f 0",
               cyc, res_sum, res_cout);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    bit acc; int cyc;
    applyStimulus(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, acc);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({req_ready, res_valid, res_cout} !== 3'b100 || res_sum !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset_async: got rdy/vld/cout=%b sum=%h expected 100 sum=0",
               {req_ready, res_valid, res_cout}, res_sum);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, res_valid, res_cout} !== 3'b100 || res_sum !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset_held: got rdy/vld/cout=%b sum=%h expected 100 sum=0",
               {req_ready, res_valid, res_cout}, res_sum);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(64'h1, 64'h2, 1'b0, acc);
    wait_result(cyc);
    tests_run++;
    if (!acc || cyc !== 4 || res_sum !== 64'h3 || res_cout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_recover: got acc=%0d cyc=%0d sum=%h cout=%b expected 1 4 3 0",
               acc, cyc, res_sum, res_cout);
    end
    release_result();
  endtask

`ifdef CSA_SEQ_SUB_EN
  task automatic test_subtract();
    bit acc; int cyc;
    req_sub = 1'b1;
    applyStimulus(64'h5, 64'h3, 1'b0, acc);
    wait_result(cyc);
    tests_run++;
    if (!acc || res_sum !== 64'h2 || res_cout !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sub_no_borrow: got acc=%0d sum=%h cout=%b expected 1 2 1", acc, res_sum, res_cout);
    end
    release_result();
    applyStimulus(64'h0, 64'h1, 1'b1, acc);
    wait_result(cyc);
    tests_run++;
    if (!acc || res_sum !== 64'hFFFF_FFFF_FFFF_FFFF || res_cout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sub_borrow: got acc=%0d sum=%h cout=%b expected 1 ffffffffffffffff 0",
               acc, res_sum, res_cout);
    end
    release_result();
    req_sub = 1'b0;
  endtask
`endif

  task automatic test_words1();
    int cyc = 0;
    req_a1 = 16'hFFFF; req_b1 = 16'h0001; req_cin1 = 1'b0;
    tests_run++;
    if (req_ready1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL w1_ready: got %b expected 1", req_ready1);
    end
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    while (!res_valid1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    tests_run++;
    if (cyc !== 1 || res_sum1 !== 16'h0000 || res_cout1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL w1_result: got cyc=%0d sum=%h cout=%b expected 1 0000 1",
               cyc, res_sum1, res_cout1);
    end
    res_ready1 = 1'b1;
    @(posedge clk); #1;
    res_ready1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_cin = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b0;
    req_valid1 = 1'b0; req_cin1 = 1'b0; req_a1 = '0; req_b1 = '0; res_ready1 = 1'b0;
`ifdef CSA_SEQ_SUB_EN
    req_sub = 1'b0; req_sub1 = 1'b0;
`endif
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_backpressure();
    test_reset_mid_run();
`ifdef CSA_SEQ_SUB_EN
    test_subtract();
`endif
    test_words1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
